// File: rtl/ndp_pkg.sv
// ndp_pkg: definitions shared by the NDP operand-load streamer.
//   NDP_BUS_WIDTH    word width of the memory and the NDP_core load bus.
//   ndp_a_words      words per A column.
//   ndp_b_words      words per B row.
//   ndp_total        words streamed for one full operand load.
//   ndp_state_e      streamer FSM states.
package ndp_pkg;

  localparam int NDP_BUS_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DRAIN     = 3'd2,
    WAIT_CALC = 3'd3,
    DONE      = 3'd4
  } ndp_state_e;

  function automatic int ndp_a_words(input int sys_height, input int arr_height, input int width);
    return (sys_height * arr_height * width) / NDP_BUS_WIDTH;
  endfunction

  function automatic int ndp_b_words(input int sys_width, input int arr_width, input int width);
    return (sys_width * arr_width * width) / NDP_BUS_WIDTH;
  endfunction

  function automatic int ndp_total(input int k_depth, input int a_words, input int b_words);
    return k_depth * (a_words + b_words);
  endfunction

endpackage

// File: rtl/ndp_prefetch_fifo.sv
// ndp_prefetch_fifo: 2-entry, 32-bit FIFO with a registered head.
//   clk, reset   clock, synchronous active-high reset (empties the FIFO)
//   push_i       write push_data_i this edge (ignored when full)
//   push_data_i  word to write
//   pop_i        drop the head this edge (caller only pops when non-empty)
//   head_o       oldest entry, straight from a register
//   count_o      occupancy 0..2
// Push and pop in the same cycle are both honoured.
module ndp_prefetch_fifo
  import ndp_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [NDP_BUS_WIDTH-1:0] push_data_i,
  input  logic                     pop_i,
  output logic [NDP_BUS_WIDTH-1:0] head_o,
  output logic [1:0]               count_o
);

  logic [NDP_BUS_WIDTH-1:0] head_q, head_d;
  logic [NDP_BUS_WIDTH-1:0] tail_q, tail_d;
  logic [1:0]               count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d  = push_data_i;
          count_d = 2'd1;
        end else if (count_q == 2'd1) begin
          tail_d  = push_data_i;
          count_d = 2'd2;
        end
      end
      2'b01: begin
        if (count_q != 2'd0) begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
      end
      2'b11: begin
        // Occupancy is unchanged; the new word lands wherever the shift leaves room.
        if (count_q == 2'd0) begin
          head_d  = push_data_i;
          count_d = 2'd1;
        end else if (count_q == 2'd1) begin
          head_d = push_data_i;
        end else begin
          head_d = tail_q;
          tail_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/ndp_operand_streamer.sv
// ndp_operand_streamer: fetches A columns and B rows from word memory and
// streams them to NDP_core as A col 0, B row 0, A col 1, B row 1, ...
//   clk, reset           clock, synchronous active-high reset
//   start                one-cycle request, sampled only in IDLE
//   a_base, b_base       word address of A column 0 / B row 0, latched on start
//   busy, done           run in progress / one-cycle completion pulse
//   mem_rd_en/_addr      read request; mem_rd_data valid one cycle later
//   data_in_flag/data_in outgoing stream
//   data_read_flag       sink accepted data_in at this edge
//   calc_done_flag       NDP_core result ready (looked at only in WAIT_CALC)
//   stream_checksum      sum of accepted words (NDP_STREAM_CHECKSUM_EN), else 0
//   dbg_state_o          current FSM state
// Optional feature macro: NDP_STREAM_CHECKSUM_EN.
//
// Handshake: data_in is valid whenever data_in_flag is high; a word transfers
// on every rising edge where data_in_flag and data_read_flag are both high.
// data_in changes only on such an edge; data_read_flag with data_in_flag low
// has no effect.
module ndp_operand_streamer
  import ndp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int ARR_HEIGHT = 4,
  parameter int ARR_WIDTH  = 4,
  parameter int SYS_HEIGHT = 1,
  parameter int SYS_WIDTH  = 64,
  parameter int K_DEPTH    = 21,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] a_base,
  input  logic [ADDR_WIDTH-1:0] b_base,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [31:0]           mem_rd_data,
  output logic                  data_in_flag,
  output logic [31:0]           data_in,
  input  logic                  data_read_flag,
  input  logic                  calc_done_flag,
  output logic [31:0]           stream_checksum,
  output logic [2:0]            dbg_state_o
);

  localparam int A_WORDS = ndp_a_words(SYS_HEIGHT, ARR_HEIGHT, WIDTH);
  localparam int B_WORDS = ndp_b_words(SYS_WIDTH, ARR_WIDTH, WIDTH);
  localparam int MAX_AB  = (A_WORDS > B_WORDS) ? A_WORDS : B_WORDS;
  localparam int MAXV    = (MAX_AB > K_DEPTH) ? MAX_AB : K_DEPTH;
  localparam int CW      = $clog2(MAXV) + 1;

  localparam logic [CW-1:0]         A_LAST   = CW'(A_WORDS - 1);
  localparam logic [CW-1:0]         B_LAST   = CW'(B_WORDS - 1);
  localparam logic [CW-1:0]         K_LAST   = CW'(K_DEPTH - 1);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  ndp_state_e            state_q;
  logic [ADDR_WIDTH-1:0] a_ptr_q, b_ptr_q;
  logic [CW-1:0]         i_q, j_q;
  logic                  phase_b_q;   // 0: sending A column j, 1: sending B row j
  logic                  rd_pend_q;   // read issued last cycle, data on mem_rd_data now
  logic                  busy_q, done_q;

  logic [1:0] occ;
  logic [1:0] used;
  logic       pop, issue, last_word;

  assign data_in_flag = (occ != 2'd0);
  assign pop          = data_in_flag & data_read_flag;

  // Credits held = FIFO entries + read in flight; a pop this cycle returns
  // its credit immediately so a full-rate sink sees one word every cycle.
  // The invariant occ + rd_pend_q <= 2 keeps this in 2 bits.
  assign used  = occ + {1'b0, rd_pend_q} - {1'b0, pop};
  assign issue = (state_q == FETCH) && (used < 2'd2);

  assign mem_rd_en   = issue;
  assign mem_rd_addr = issue ? (phase_b_q ? b_ptr_q : a_ptr_q) : '0;

  // With every read issued, the final word leaves when the FIFO holds one
  // entry and nothing is returning from memory.
  assign last_word = pop && (occ == 2'd1) && !rd_pend_q;

  ndp_prefetch_fifo u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (rd_pend_q),
    .push_data_i (mem_rd_data),
    .pop_i       (pop),
    .head_o      (data_in),
    .count_o     (occ)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_ptr_q   <= '0;
      b_ptr_q   <= '0;
      i_q       <= '0;
      j_q       <= '0;
      phase_b_q <= 1'b0;
      rd_pend_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rd_pend_q <= issue;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= FETCH;
            busy_q    <= 1'b1;
            a_ptr_q   <= a_base;
            b_ptr_q   <= b_base;
            i_q       <= '0;
            j_q       <= '0;
            phase_b_q <= 1'b0;
          end
        end
        FETCH: begin
          if (issue) begin
            // A and B regions are each contiguous in k order, so plain
            // incrementing pointers give base + j*WORDS + i (wrapping silently).
            if (phase_b_q) b_ptr_q <= b_ptr_q + ADDR_ONE;
            else           a_ptr_q <= a_ptr_q + ADDR_ONE;
            if (!phase_b_q && (i_q == A_LAST)) begin
              phase_b_q <= 1'b1;
              i_q       <= '0;
            end else if (phase_b_q && (i_q == B_LAST)) begin
              phase_b_q <= 1'b0;
              i_q       <= '0;
              j_q       <= j_q + CNT_ONE;
              if (j_q == K_LAST) state_q <= DRAIN;
            end else begin
              i_q <= i_q + CNT_ONE;
            end
          end
        end
        DRAIN: begin
          if (last_word) state_q <= WAIT_CALC;
        end
        WAIT_CALC: begin
          if (calc_done_flag) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

`ifdef NDP_STREAM_CHECKSUM_EN
  logic [31:0] csum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      csum_q <= '0;
    end else if (pop) begin
      csum_q <= csum_q + data_in;
    end
  end

  assign stream_checksum = csum_q;
`else
  assign stream_checksum = '0;
`endif

endmodule
